// File: rtl/rv32_mem_arb_pkg.sv
// Shared types for the RV32 instruction/data memory-bus arbiter.
package rv32_mem_arb_pkg;

  localparam int RV32_XLEN = 32;

  typedef enum logic [1:0] {
    IDLE,
    GRANT_INSTR,
    GRANT_DATA
  } rv32_mem_arb_state_t;

  typedef enum logic {
    INSTR,
    DATA
  } rv32_mem_arb_owner_t;

endpackage

// File: rtl/rv32_mem_arb_watchdog.sv
// Bus-timeout watchdog: counts grant cycles without slave completion and
// flags expiry on the TIMEOUT_CYCLES-th such cycle. TIMEOUT_CYCLES=0 removes it.
module rv32_mem_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic ready,
  output logic expire
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      assign expire = 1'b0;
    end else begin : g_on
      localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

      logic [CNT_W-1:0] count;

      // A slave completion in the expiry cycle wins, so expire needs !ready.
      assign expire = active && !ready && (count == LAST);

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          count <= '0;
        end else if (!active || ready || expire) begin
          count <= '0;
        end else begin
          count <= count + 1'b1;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/rv32_mem_arbiter.sv
// Shares one memory bus between instruction fetch and the mem stage.
// Optional RV32_MEM_ARB_ROUND_ROBIN_EN alternates ownership on conflicts.
module rv32_mem_arbiter
  import rv32_mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 instr_read_en_in,
  input  logic [RV32_XLEN-1:0] instr_address_in,
  output logic [RV32_XLEN-1:0] instr_read_value_out,
  output logic                 instr_ready_out,
  input  logic                 data_read_en_in,
  input  logic                 data_write_en_in,
  input  logic [RV32_XLEN-1:0] data_address_in,
  input  logic [3:0]           data_write_mask_in,
  input  logic [RV32_XLEN-1:0] data_write_value_in,
  output logic [RV32_XLEN-1:0] data_read_value_out,
  output logic                 data_ready_out,
  output logic [RV32_XLEN-1:0] bus_address_out,
  output logic                 bus_read_en_out,
  output logic                 bus_write_en_out,
  output logic [3:0]           bus_write_mask_out,
  output logic [RV32_XLEN-1:0] bus_write_value_out,
  input  logic [RV32_XLEN-1:0] bus_read_value_in,
  input  logic                 bus_ready_in,
  output logic                 bus_fault_out
);

  rv32_mem_arb_state_t state, state_next;

  logic data_req;
  logic grant_active;
  logic expire;
  logic done;
  logic prefer_data;
  logic data_is_write;

  assign data_req     = data_read_en_in | data_write_en_in;
  assign grant_active = (state != IDLE);
  assign done         = grant_active && (bus_ready_in || expire);

  rv32_mem_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .active (grant_active),
    .ready  (bus_ready_in),
    .expire (expire)
  );

`ifdef RV32_MEM_ARB_ROUND_ROBIN_EN
  rv32_mem_arb_owner_t last_owner;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_owner <= INSTR;
    end else if (done) begin
      last_owner <= (state == GRANT_DATA) ? DATA : INSTR;
    end
  end

  assign prefer_data = (last_owner == INSTR);
`else
  assign prefer_data = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Access kind is latched at grant so the strobe holds even if the requester misbehaves.
  always_ff @(posedge clk) begin
    if (state_next == GRANT_DATA && state != GRANT_DATA) begin
      data_is_write <= data_write_en_in;
    end
  end

  always_comb begin
    state_next           = state;
    bus_address_out      = '0;
    bus_read_en_out      = 1'b0;
    bus_write_en_out     = 1'b0;
    bus_write_mask_out   = '0;
    bus_write_value_out  = '0;
    instr_ready_out      = 1'b0;
    instr_read_value_out = '0;
    data_ready_out       = 1'b0;
    data_read_value_out  = '0;
    bus_fault_out        = 1'b0;

    case (state)
      IDLE: begin
        if (data_req && (prefer_data || !instr_read_en_in)) begin
          state_next = GRANT_DATA;
        end else if (instr_read_en_in) begin
          state_next = GRANT_INSTR;
        end
      end

      GRANT_INSTR: begin
        bus_address_out = instr_address_in;
        bus_read_en_out = 1'b1;
        if (done) begin
          // A dropped request still consumes the grant; its result is discarded.
          instr_ready_out      = instr_read_en_in;
          instr_read_value_out = (instr_read_en_in && bus_ready_in) ? bus_read_value_in : '0;
          bus_fault_out        = !bus_ready_in;
          state_next           = data_req ? GRANT_DATA : IDLE;
        end
      end

      GRANT_DATA: begin
        bus_address_out     = data_address_in;
        bus_read_en_out     = !data_is_write;
        bus_write_en_out    = data_is_write;
        bus_write_mask_out  = data_write_mask_in;
        bus_write_value_out = data_write_value_in;
        if (done) begin
          data_ready_out      = data_req;
          data_read_value_out = (data_req && bus_ready_in) ? bus_read_value_in : '0;
          bus_fault_out       = !bus_ready_in;
          state_next          = instr_read_en_in ? GRANT_INSTR : IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Self-checking bench for rv32_mem_arbiter: directed scenarios plus randomized
// traffic compared every cycle against a transaction-level owner/wait model.
module tb_rv32_mem_arbiter;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic        req_rd = 1'b0;
  logic        req_wr = 1'b0;
  logic [31:0] daddr = '0;
  logic [3:0]  dmask = '0;
  logic [31:0] dval = '0;
  logic        bready = 1'b0;
  logic [31:0] brdata = '0;

  logic [31:0] instr_read_value_out, data_read_value_out, bus_address_out, bus_write_value_out;
  logic        instr_ready_out, data_ready_out, bus_read_en_out, bus_write_en_out, bus_fault_out;
  logic [3:0]  bus_write_mask_out;

  rv32_mem_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk                  (clk),
    .reset                (reset),
    .instr_read_en_in     (req_i),
    .instr_address_in     (addr_i),
    .instr_read_value_out (instr_read_value_out),
    .instr_ready_out      (instr_ready_out),
    .data_read_en_in      (req_rd),
    .data_write_en_in     (req_wr),
    .data_address_in      (daddr),
    .data_write_mask_in   (dmask),
    .data_write_value_in  (dval),
    .data_read_value_out  (data_read_value_out),
    .data_ready_out       (data_ready_out),
    .bus_address_out      (bus_address_out),
    .bus_read_en_out      (bus_read_en_out),
    .bus_write_en_out     (bus_write_en_out),
    .bus_write_mask_out   (bus_write_mask_out),
    .bus_write_value_out  (bus_write_value_out),
    .bus_read_value_in    (brdata),
    .bus_ready_in         (bready),
    .bus_fault_out        (bus_fault_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: who owns the bus (0 none, 1 fetch, 2 data), wait cycles so far, last completed owner.
  int m_owner = 0;
  int m_wait  = 0;
  int m_last  = 1;
  logic last_done_i = 1'b0;
  logic last_done_d = 1'b0;

  // Observations from the most recent tick, plus event counters.
  logic        obs_ir, obs_dr, obs_rd, obs_wr, obs_f;
  logic [31:0] obs_addr, obs_iv, obs_dv, obs_wv;
  logic [3:0]  obs_m;
  int cnt_rd, cnt_ir, cnt_dr, cnt_f;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_cnt();
    cnt_rd = 0; cnt_ir = 0; cnt_dr = 0; cnt_f = 0;
  endtask

  // Called at a falling edge with inputs already set: compare, then advance one clock.
  task automatic tick();
    logic        e_rd, e_wr, e_ir, e_dr, e_f, tmo, done, dreq;
    logic [31:0] e_addr, e_wv, e_iv, e_dv;
    logic [3:0]  e_m;
    #1;
    e_rd = 0; e_wr = 0; e_ir = 0; e_dr = 0; e_f = 0;
    e_addr = 0; e_wv = 0; e_iv = 0; e_dv = 0; e_m = 0;
    dreq = req_rd | req_wr;
    tmo  = (m_owner != 0) && (m_wait == TMO - 1) && !bready;
    done = (m_owner != 0) && (bready || tmo);
    if (m_owner == 1) begin
      e_addr = addr_i;
      e_rd   = 1;
      e_ir   = done;
      e_iv   = (done && bready) ? brdata : 32'h0;
    end else if (m_owner == 2) begin
      e_addr = daddr;
      e_rd   = req_rd;
      e_wr   = req_wr;
      e_m    = dmask;
      e_wv   = dval;
      e_dr   = done;
      e_dv   = (done && bready) ? brdata : 32'h0;
    end
    e_f = tmo;

    obs_ir = instr_ready_out; obs_dr = data_ready_out; obs_rd = bus_read_en_out;
    obs_wr = bus_write_en_out; obs_f = bus_fault_out; obs_addr = bus_address_out;
    obs_iv = instr_read_value_out; obs_dv = data_read_value_out;
    obs_wv = bus_write_value_out; obs_m = bus_write_mask_out;
    cnt_rd += int'(obs_rd); cnt_ir += int'(obs_ir); cnt_dr += int'(obs_dr); cnt_f += int'(obs_f);

    chk("bus_addr",    obs_addr, e_addr);
    chk("bus_rd",      {31'h0, obs_rd}, {31'h0, e_rd});
    chk("bus_wr",      {31'h0, obs_wr}, {31'h0, e_wr});
    chk("bus_mask",    {28'h0, obs_m}, {28'h0, e_m});
    chk("bus_wval",    obs_wv, e_wv);
    chk("instr_ready", {31'h0, obs_ir}, {31'h0, e_ir});
    chk("instr_val",   obs_iv, e_iv);
    chk("data_ready",  {31'h0, obs_dr}, {31'h0, e_dr});
    chk("data_val",    obs_dv, e_dv);
    chk("bus_fault",   {31'h0, obs_f}, {31'h0, e_f});

    @(posedge clk);
    last_done_i = done && (m_owner == 1);
    last_done_d = done && (m_owner == 2);
    if (m_owner == 0) begin
      m_wait = 0;
      if (dreq && req_i) begin
`ifdef RV32_MEM_ARB_ROUND_ROBIN_EN
        m_owner = (m_last == 1) ? 2 : 1;
`else
        m_owner = 2;
`endif
      end else if (dreq) m_owner = 2;
      else if (req_i) m_owner = 1;
    end else if (done) begin
      m_last = m_owner;
      m_wait = 0;
      if (m_owner == 1) m_owner = dreq ? 2 : 0;
      else              m_owner = req_i ? 1 : 0;
    end else begin
      m_wait++;
    end
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_rd",    {31'h0, bus_read_en_out}, 32'h0);
    chk("rst_wr",    {31'h0, bus_write_en_out}, 32'h0);
    chk("rst_ready", {30'h0, instr_ready_out, data_ready_out}, 32'h0);
    chk("rst_fault", {31'h0, bus_fault_out}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Single fetch with three wait states; ready coincides with the timeout boundary.
    clear_cnt();
    req_i = 1; addr_i = 32'h100;
    tick();
    for (int k = 0; k < 3; k++) tick();
    bready = 1; brdata = 32'hDEADBEEF;
    tick();
    chk("fetch_val", obs_iv, 32'hDEADBEEF);
    req_i = 0; bready = 0;
    tick();
    chk("fetch_rd_cycles", cnt_rd, 4);
    chk("fetch_ready_cnt", cnt_ir, 1);
    chk("fetch_fault_cnt", cnt_f, 0);
    chk("fetch_idle_rd", {31'h0, obs_rd}, 32'h0);

    // Three conflicting rounds: data completes first, fetch follows with no bubble.
    for (int r = 0; r < 3; r++) begin
      req_i = 1; addr_i = 32'h200; req_rd = 1; daddr = 32'h300; bready = 0;
      tick();
      bready = 1; brdata = 32'hA000_0000 + r;
      tick();
      chk("conf_data_ready", {31'h0, obs_dr}, 32'h1);
      chk("conf_data_addr", obs_addr, 32'h300);
      chk("conf_data_val", obs_dv, 32'hA000_0000 + r);
      req_rd = 0; brdata = 32'hB000_0000 + r;
      tick();
      chk("conf_instr_ready", {31'h0, obs_ir}, 32'h1);
      chk("conf_instr_addr", obs_addr, 32'h200);
      chk("conf_instr_val", obs_iv, 32'hB000_0000 + r);
      req_i = 0; bready = 0;
      tick();
    end

    // Store
    req_wr = 1; daddr = 32'h400; dmask = 4'b0011; dval = 32'h1234;
    tick();
    bready = 1; brdata = 32'h5555_5555;
    tick();
    chk("store_wr", {31'h0, obs_wr}, 32'h1);
    chk("store_rd", {31'h0, obs_rd}, 32'h0);
    chk("store_mask", {28'h0, obs_m}, 32'h3);
    chk("store_val", obs_wv, 32'h1234);
    chk("store_ready", {31'h0, obs_dr}, 32'h1);
    req_wr = 0; bready = 0;
    tick();

    // Dead slave: forced completion on the fourth grant cycle.
    clear_cnt();
    req_rd = 1; daddr = 32'h500; brdata = 32'hFFFF_FFFF;
    tick();
    for (int k = 0; k < 4; k++) tick();
    chk("tmo_ready", {31'h0, obs_dr}, 32'h1);
    chk("tmo_val", obs_dv, 32'h0);
    chk("tmo_fault", {31'h0, obs_f}, 32'h1);
    req_rd = 0;
    tick();
    chk("tmo_fault_cnt", cnt_f, 1);
    chk("tmo_grant_cycles", cnt_rd, 4);

    // Reset in the second grant cycle of a load.
    clear_cnt();
    req_rd = 1; daddr = 32'h600;
    tick();
    tick();
    #1;
    chk("mid_rd_before", {31'h0, bus_read_en_out}, 32'h1);
    reset = 1;
    #1;
    chk("mid_rd_after", {31'h0, bus_read_en_out}, 32'h0);
    chk("mid_ready", {31'h0, data_ready_out}, 32'h0);
    chk("mid_fault", {31'h0, bus_fault_out}, 32'h0);
    @(negedge clk);
    reset = 0; req_rd = 0;
    m_owner = 0; m_wait = 0; m_last = 1;
    tick();
    chk("mid_ready_cnt", cnt_dr, 0);
    req_i = 1; addr_i = 32'h700; bready = 1; brdata = 32'h0C0FFEE0;
    tick();
    chk("post_rst_idle", {31'h0, obs_rd}, 32'h0);
    tick();
    chk("post_rst_fetch", obs_iv, 32'h0C0FFEE0);
    req_i = 0; bready = 0;
    tick();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if (last_done_i) req_i = 0;
      if (last_done_d) begin req_rd = 0; req_wr = 0; end
      if (!req_i && ($urandom_range(2, 0) == 0)) begin
        req_i = 1; addr_i = $urandom;
      end
      if (!req_rd && !req_wr && ($urandom_range(2, 0) == 0)) begin
        if ($urandom_range(1, 0) == 1) req_wr = 1; else req_rd = 1;
        daddr = $urandom; dmask = 4'($urandom); dval = $urandom;
      end
      bready = ($urandom_range(9, 0) < 3);
      brdata = $urandom;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
